// File: rtl/peripheral_division_32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_division_32_pkg
//  Description : Shared register offsets and divider FSM state encoding for
//                the memory-mapped 32-bit divider.
//  Revision    : 1.0 - initial release
// ============================================================================
package peripheral_division_32_pkg;

    // Register offsets (byte addresses, even only)
    localparam logic [3:0] ADDR_GO      = 4'h0;
    localparam logic [3:0] ADDR_DVD_HI  = 4'h2;
    localparam logic [3:0] ADDR_DVD_LO  = 4'h4;
    localparam logic [3:0] ADDR_DVS_HI  = 4'h6;
    localparam logic [3:0] ADDR_DVS_LO  = 4'h8;
    localparam logic [3:0] ADDR_DONE    = 4'hA;
    localparam logic [3:0] ADDR_QUOT_HI = 4'hC;
    localparam logic [3:0] ADDR_QUOT_LO = 4'hE;

    // Divider core sequencing
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } div_state_t;

endpackage
`default_nettype wire

// File: rtl/div32_core.sv
`default_nettype none
// ============================================================================
//  Module      : div32_core
//  Description : Restoring shift-subtract unsigned divider, one quotient bit
//                per clock. Operands are latched on start so the bus side is
//                free to rewrite them while a division runs. A zero divisor
//                naturally yields an all-ones quotient.
//  Revision    : 1.0 - initial release
// ============================================================================
module div32_core
    import peripheral_division_32_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,          // asynchronous, active low
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             busy,
    output logic             done_pulse,
    output logic             div0
);

    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    div_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_work;   // dividend shifts out the top, quotient bits shift in
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_quot;
    logic             r_div0;

    logic [WIDTH:0]   w_shift;
    logic [WIDTH:0]   w_diff;
    logic             w_fits;

    // Partial remainder with next dividend bit appended; no borrow means it fits
    assign w_shift = {r_rem, r_work[WIDTH-1]};
    assign w_diff  = w_shift - {1'b0, r_dvs};
    assign w_fits  = ~w_diff[WIDTH];

    // Sequencer: latch on start, iterate WIDTH times, publish result in FIN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_rem   <= '0;
            r_work  <= '0;
            r_dvs   <= '0;
            r_quot  <= '0;
            r_div0  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_rem   <= '0;
                        r_work  <= dividend;
                        r_dvs   <= divisor;
                        r_div0  <= (divisor == '0);
                        r_cnt   <= CNT_LAST;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_rem  <= w_fits ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
                    r_work <= {r_work[WIDTH-2:0], w_fits};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIN;
                    end else begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                ST_FIN: begin
                    r_quot  <= r_work;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign quotient   = r_quot;
    assign busy       = (r_state != ST_IDLE);
    assign done_pulse = (r_state == ST_FIN);
    assign div0       = r_div0;

endmodule
`default_nettype wire

// File: rtl/peripheral_division_32.sv
`default_nettype none
// ============================================================================
//  Module      : peripheral_division_32
//  Description : 16-bit bus register file and read mux around div32_core.
//                Start fires on a 0->1 write of the GO bit while the core is
//                idle. Optional macro DIVZERO_FLAG_EN exposes the
//                divide-by-zero flag of the last operation in DONE bit1.
//  Revision    : 1.0 - initial release
// ============================================================================
module peripheral_division_32
    import peripheral_division_32_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int BUS_W = 16
) (
    input  logic             clk,
    input  logic             rst,      // asynchronous, active low
    input  logic [BUS_W-1:0] d_in,
    input  logic             cs,
    input  logic [3:0]       addr,
    input  logic             rd,
    input  logic             wr,
    output logic [BUS_W-1:0] d_out
);

    logic             r_go;
    logic [WIDTH-1:0] r_dividend;
    logic [WIDTH-1:0] r_divisor;
    logic             r_done;

    logic             w_start;
    logic             w_busy;
    logic             w_done_pulse;
    logic [WIDTH-1:0] w_quotient;
    logic [BUS_W-1:0] w_done_word;
    logic [BUS_W-1:0] w_rd_data;

    // Stored GO goes 0->1 on this write; ignored while a division is in flight
    assign w_start = cs && wr && (addr == ADDR_GO) && d_in[0] && !r_go && !w_busy;

`ifdef DIVZERO_FLAG_EN
    logic w_div0;
    logic r_div0_flag;

    // Divide-by-zero flag follows DONE: cleared at start, set at completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div0_flag <= 1'b0;
        end else if (w_start) begin
            r_div0_flag <= 1'b0;
        end else if (w_done_pulse) begin
            r_div0_flag <= w_div0;
        end
    end

    assign w_done_word = {{(BUS_W-2){1'b0}}, r_div0_flag, r_done};
`else
    assign w_done_word = {{(BUS_W-1){1'b0}}, r_done};
`endif

    div32_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .dividend   (r_dividend),
        .divisor    (r_divisor),
        .quotient   (w_quotient),
        .busy       (w_busy),
        .done_pulse (w_done_pulse),
`ifdef DIVZERO_FLAG_EN
        .div0       (w_div0)
`else
        .div0       ()
`endif
    );

    // Bus writes into GO and operand halves; read-only and odd offsets drop
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_go       <= 1'b0;
            r_dividend <= '0;
            r_divisor  <= '0;
        end else if (cs && wr) begin
            case (addr)
                ADDR_GO:     r_go                     <= d_in[0];
                ADDR_DVD_HI: r_dividend[WIDTH-1:BUS_W] <= d_in;
                ADDR_DVD_LO: r_dividend[BUS_W-1:0]     <= d_in;
                ADDR_DVS_HI: r_divisor[WIDTH-1:BUS_W]  <= d_in;
                ADDR_DVS_LO: r_divisor[BUS_W-1:0]      <= d_in;
                default: ;
            endcase
        end
    end

    // DONE is cleared at start and held from completion until the next start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done <= 1'b0;
        end else if (w_start) begin
            r_done <= 1'b0;
        end else if (w_done_pulse) begin
            r_done <= 1'b1;
        end
    end

    // Read mux; unmapped offsets return zero
    always_comb begin
        w_rd_data = '0;
        case (addr)
            ADDR_GO:      w_rd_data = {{(BUS_W-1){1'b0}}, r_go};
            ADDR_DVD_HI:  w_rd_data = r_dividend[WIDTH-1:BUS_W];
            ADDR_DVD_LO:  w_rd_data = r_dividend[BUS_W-1:0];
            ADDR_DVS_HI:  w_rd_data = r_divisor[WIDTH-1:BUS_W];
            ADDR_DVS_LO:  w_rd_data = r_divisor[BUS_W-1:0];
            ADDR_DONE:    w_rd_data = w_done_word;
            ADDR_QUOT_HI: w_rd_data = w_quotient[WIDTH-1:BUS_W];
            ADDR_QUOT_LO: w_rd_data = w_quotient[BUS_W-1:0];
            default:      w_rd_data = '0;
        endcase
    end

    // Registered read data, zero whenever no read is addressed to us
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            d_out <= '0;
        end else if (cs && rd) begin
            d_out <= w_rd_data;
        end else begin
            d_out <= '0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_peripheral_division_32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_peripheral_division_32
//  Description : Self-checking bench for peripheral_division_32. Bus reads
//                push their expected value to a scoreboard queue; the value
//                is popped and compared when registered read data appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_peripheral_division_32;

    localparam logic [3:0] A_GO = 4'h0, A_DVD_HI = 4'h2, A_DVD_LO = 4'h4;
    localparam logic [3:0] A_DVS_HI = 4'h6, A_DVS_LO = 4'h8, A_DONE = 4'hA;
    localparam logic [3:0] A_QH = 4'hC, A_QL = 4'hE;
`ifdef DIVZERO_FLAG_EN
    localparam logic [15:0] DIV0_DONE = 16'h0003;
`else
    localparam logic [15:0] DIV0_DONE = 16'h0001;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] d_in = '0;
    logic        cs = 1'b0;
    logic [3:0]  addr = '0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [15:0] d_out;

    int checks   = 0;
    int failures = 0;

    logic [15:0] sb_exp[$];
    string       sb_name[$];

    typedef struct {
        logic [31:0] dvd;
        logic [31:0] dvs;
        logic [31:0] quot;
    } vec_t;
    vec_t vecs[9];

    peripheral_division_32 dut (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .cs    (cs),
        .addr  (addr),
        .rd    (rd),
        .wr    (wr),
        .d_out (d_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // All bus tasks start and end on a negedge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [3:0] a, input logic [15:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; d_in = d;
        @(negedge clk);
        cs = 1'b0; wr = 1'b0; d_in = '0;
    endtask

    task automatic bus_read(input logic [3:0] a, input logic [15:0] exp, input string name);
        logic [15:0] e;
        string       n;
        cs = 1'b1; rd = 1'b1; addr = a;
        sb_exp.push_back(exp);
        sb_name.push_back(name);
        @(negedge clk);
        cs = 1'b0; rd = 1'b0;
        e = sb_exp.pop_front();
        n = sb_name.pop_front();
        check(n, {16'h0, d_out}, {16'h0, e});
    endtask

    task automatic write_ops(input logic [31:0] dvd, input logic [31:0] dvs);
        bus_write(A_DVD_HI, dvd[31:16]);
        bus_write(A_DVD_LO, dvd[15:0]);
        bus_write(A_DVS_HI, dvs[31:16]);
        bus_write(A_DVS_LO, dvs[15:0]);
    endtask

    // Poll DONE bit0 with a bounded budget
    task automatic wait_done(input string name);
        bit seen = 1'b0;
        cs = 1'b1; rd = 1'b1; addr = A_DONE;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (d_out[0]) begin
                seen = 1'b1;
                break;
            end
        end
        cs = 1'b0; rd = 1'b0;
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_div(input logic [31:0] dvd, input logic [31:0] dvs, input string name);
        write_ops(dvd, dvs);
        bus_write(A_GO, 16'h0001);
        bus_write(A_GO, 16'h0000);
        wait_done(name);
    endtask

    initial begin
        int first_k;

        vecs[0] = '{32'd1000,      32'd5,          32'd200};
        vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001,  32'hFFFF_FFFF};
        vecs[2] = '{32'd7,         32'd0,          32'hFFFF_FFFF};
        vecs[3] = '{32'd3,         32'd10,         32'd0};
        vecs[4] = '{32'h1234_5678, 32'h0000_1234,  32'h0001_0004};
        vecs[5] = '{32'd100,       32'd100,        32'd1};
        vecs[6] = '{32'h8000_0000, 32'hFFFF_FFFF,  32'd0};
        vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'd1};
        vecs[8] = '{32'hFFFF_FFFE, 32'd2,          32'h7FFF_FFFF};

        idle(3);
        rst = 1'b1;
        idle(2);

        // Reset state
        bus_read(A_GO,   16'h0000, "rst_go");
        bus_read(A_DVD_HI, 16'h0000, "rst_dvd_hi");
        bus_read(A_DONE, 16'h0000, "rst_done");
        bus_read(A_QL,   16'h0000, "rst_quot_lo");

        // Table-driven divisions
        for (int i = 0; i < 9; i++) begin
            run_div(vecs[i].dvd, vecs[i].dvs, $sformatf("vec%0d", i));
            bus_read(A_DONE, (vecs[i].dvs == 0) ? DIV0_DONE : 16'h0001,
                     $sformatf("vec%0d_done", i));
            bus_read(A_QH, vecs[i].quot[31:16], $sformatf("vec%0d_qhi", i));
            bus_read(A_QL, vecs[i].quot[15:0],  $sformatf("vec%0d_qlo", i));
        end

        // Operand readback, ignored writes, odd offsets
        bus_read(A_DVD_HI, 16'hFFFF, "rb_dvd_hi");
        bus_read(A_DVS_LO, 16'h0002, "rb_dvs_lo");
        bus_write(A_QL, 16'h1234);
        bus_write(4'h3, 16'hAAAA);
        bus_write(A_DONE, 16'h0000);
        bus_read(A_QL, 16'hFFFF, "ro_quot_lo");
        bus_read(A_DVD_HI, 16'hFFFF, "odd_write_ignored");
        bus_read(4'h3, 16'h0000, "odd_read_zero");
        bus_read(A_DONE, 16'h0001, "ro_done");
        idle(1);
        check("dout_idle", {16'h0, d_out}, 32'h0);

        // Exact latency: DONE register set by edge 33, seen on d_out one edge later
        write_ops(32'hFFFF_FFFF, 32'h0000_0001);
        bus_write(A_GO, 16'h0001);
        first_k = 0;
        cs = 1'b1; rd = 1'b1; addr = A_DONE;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (d_out[0] && first_k == 0) first_k = k;
        end
        cs = 1'b0; rd = 1'b0;
        check("done_latency", first_k, 34);
        bus_read(A_QH, 16'hFFFF, "lat_qhi");
        bus_read(A_QL, 16'hFFFF, "lat_qlo");
        bus_write(A_GO, 16'h0000);

        // Divide by zero then flag clears on the next normal op
        run_div(32'd7, 32'd0, "div0");
        bus_read(A_DONE, DIV0_DONE, "div0_done");
        run_div(32'd9, 32'd3, "after_div0");
        bus_read(A_DONE, 16'h0001, "div0_cleared");
        bus_read(A_QL, 16'h0003, "after_div0_qlo");

        // GO held high for 40 clocks: one operation only
        write_ops(32'd3, 32'd10);
        cs = 1'b1; wr = 1'b1; addr = A_GO; d_in = 16'h0001;
        idle(40);
        cs = 1'b0; wr = 1'b0; d_in = '0;
        bus_read(A_DONE, 16'h0001, "hold_done");
        bus_read(A_QL, 16'h0000, "hold_qlo");
        idle(40);
        bus_read(A_DONE, 16'h0001, "hold_done_stays");
        bus_read(A_GO, 16'h0001, "hold_go_level");
        bus_write(A_GO, 16'h0000);

        // Operands change mid-run and GO edge while busy is ignored
        write_ops(32'd1000, 32'd5);
        bus_write(A_GO, 16'h0001);
        bus_write(A_GO, 16'h0000);
        idle(3);
        bus_write(A_DVD_LO, 16'd77);
        bus_write(A_DVS_LO, 16'd7);
        bus_write(A_GO, 16'h0001);
        wait_done("midrun");
        bus_read(A_QH, 16'h0000, "midrun_qhi");
        bus_read(A_QL, 16'h00C8, "midrun_qlo");
        idle(40);
        bus_read(A_DONE, 16'h0001, "busy_go_ignored");
        bus_read(A_QL, 16'h00C8, "midrun_qlo_hold");
        bus_read(A_DVD_LO, 16'd77, "midrun_rb_dvd");
        bus_write(A_GO, 16'h0000);
        bus_write(A_GO, 16'h0001);
        bus_write(A_GO, 16'h0000);
        wait_done("newops");
        bus_read(A_QL, 16'd11, "newops_qlo");

        // Reset around iteration 10 of a division
        write_ops(32'h1234_5678, 32'h0000_1234);
        bus_write(A_GO, 16'h0001);
        idle(9);
        cs = 1'b1; rd = 1'b1; addr = A_QL;
        #2 rst = 1'b0;
        #1 check("rst_async_dout", {16'h0, d_out}, 32'h0);
        @(negedge clk);
        check("rst_hold_dout", {16'h0, d_out}, 32'h0);
        cs = 1'b0; rd = 1'b0;
        rst = 1'b1;
        idle(1);
        bus_read(A_DONE, 16'h0000, "rst_mid_done");
        bus_read(A_QH, 16'h0000, "rst_mid_qhi");
        bus_read(A_QL, 16'h0000, "rst_mid_qlo");
        bus_read(A_DVD_LO, 16'h0000, "rst_mid_dvd");
        idle(40);
        bus_read(A_DONE, 16'h0000, "rst_mid_killed");
        run_div(32'h1234_5678, 32'h0000_1234, "rerun");
        bus_read(A_QH, 16'h0001, "rerun_qhi");
        bus_read(A_QL, 16'h0004, "rerun_qlo");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire
